// File: rtl/mcse_resource_arbiter.sv
// -----------------------------------------------------------------------------
// mcse_resource_arbiter
//
// Arbitrates N_REQ boot sub-controllers onto the shared MCSE security
// resources: the secure memory port, the boot-control bus translation port and
// the SHA port. A single registered one-hot grant selects which requester's
// r_* bundle is forwarded to the resources. Return strobes (mem_rdata_valid,
// bus_done) are routed back to the owner only.
//
// Policy: ARB_MODE 0 = fixed priority (lowest index wins),
//         ARB_MODE 1 = round-robin (search starts at the slot after the last
//         winner).
// Lifecycle masking (req_mask) removes requesters from arbitration and
// revokes an active grant. A watchdog limits ownership to TIMEOUT_CYCLES
// cycles (0 disables it); a timeout sets a sticky fault bit and blocks the
// requester until it drops req for at least one cycle.
//
// Every grant ends with one HANDOVER cycle in which everything is forced low,
// followed by IDLE before the next grant, so strobes from an old owner can
// never reach a new one.
//
// Handshake: req[i] is a level. A requester raises req[i] and holds it for the
// whole time it uses the resources; it may drive its r_* bundle only while
// gnt[i] is high, and it gives the resources back by dropping req[i]. There is
// no ready/ack path beyond gnt.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req, req_mask        per-requester request / lifecycle mask (1 = forbidden)
//   gnt, busy, fault     registered one-hot grant, owned flag, sticky timeouts
//   r_mem_*, r_bus_*,
//   r_sha_*              per-requester resource bundles (flattened)
//   mem_*, bus_*, sha_*  resource-side outputs (owner's bundle or 0)
//   mem_rdata_valid,
//   bus_done             resource return strobes
//   r_mem_rdata_valid,
//   r_bus_done           return strobes routed to the owner bit only
//   dbg_state            current FSM state (0 idle, 1 grant, 2 handover)
// -----------------------------------------------------------------------------
module mcse_resource_arbiter #(
  parameter int N_REQ          = 4,
  parameter int MEM_AW         = 6,
  parameter int MEM_DW         = 256,
  parameter int BUS_AW         = 32,
  parameter int BUS_DW         = 256,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_mask,
  output logic [N_REQ-1:0]           gnt,
  output logic                       busy,
  output logic [N_REQ-1:0]           fault,
  input  logic [N_REQ-1:0]           r_mem_rd_en,
  input  logic [N_REQ-1:0]           r_mem_wr_en,
  input  logic [N_REQ*MEM_AW-1:0]    r_mem_addr,
  input  logic [N_REQ*MEM_DW-1:0]    r_mem_wdata,
  input  logic [N_REQ-1:0]           r_bus_go,
  input  logic [N_REQ-1:0]           r_bus_rw,
  input  logic [N_REQ*BUS_AW-1:0]    r_bus_addr,
  input  logic [N_REQ*BUS_DW-1:0]    r_bus_wdata,
  input  logic [N_REQ-1:0]           r_sha_init,
  input  logic [N_REQ-1:0]           r_sha_next,
  input  logic [N_REQ-1:0]           r_sha_sel,
  input  logic [N_REQ*512-1:0]       r_sha_block,
  output logic                       mem_rd_en,
  output logic                       mem_wr_en,
  output logic [MEM_AW-1:0]          mem_addr,
  output logic [MEM_DW-1:0]          mem_wdata,
  input  logic                       mem_rdata_valid,
  output logic [N_REQ-1:0]           r_mem_rdata_valid,
  output logic                       bus_go,
  output logic                       bus_rw,
  output logic [BUS_AW-1:0]          bus_addr,
  output logic [BUS_DW-1:0]          bus_wdata,
  input  logic                       bus_done,
  output logic [N_REQ-1:0]           r_bus_done,
  output logic                       sha_init,
  output logic                       sha_next,
  output logic                       sha_sel,
  output logic [511:0]               sha_block,
  output logic [1:0]                 dbg_state
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // A zero-width counter is not legal; keep at least one bit when disabled.
  localparam int CNT_W = (TMO_W < 1) ? 1 : TMO_W;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_HANDOVER = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   fault_q, fault_d;
  logic [N_REQ-1:0]   blocked_q, blocked_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;

  logic [N_REQ-1:0]   elig;
  logic [N_REQ-1:0]   win_oh;
  logic [PTR_W-1:0]   win_idx;
  logic               win_vld;
  logic               owner_live;

  assign elig       = req & ~req_mask & ~blocked_q;
  // Owner keeps the resource only while its own request is up and unmasked.
  assign owner_live = |(gnt_q & req & ~req_mask);

  // Winner search: scan N_REQ slots starting at 0 (fixed) or at the
  // round-robin pointer, wrapping past N_REQ-1.
  always_comb begin : pick_winner
    int               base;
    int               idx;
    logic [PTR_W-1:0] cand;
    base    = (ARB_MODE == 1) ? int'(ptr_q) : 0;
    idx     = 0;
    cand    = '0;
    win_vld = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = base + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = PTR_W'(idx);
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    win_oh[win_idx] = win_vld;
  end

  always_comb begin : next_state
    state_d   = state_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    fault_d   = fault_q;
    ptr_d     = ptr_q;
    wdog_d    = wdog_q;
    // A block is released by the requester dropping req for one cycle.
    blocked_d = blocked_q & req;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_GRANT;
          gnt_d   = win_oh;
          busy_d  = 1'b1;
          wdog_d  = '0;
          ptr_d   = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      ST_GRANT: begin
        if (!owner_live) begin
          // Release is checked first so it wins over a same-cycle timeout.
          state_d = ST_HANDOVER;
          gnt_d   = '0;
          busy_d  = 1'b0;
          wdog_d  = '0;
        end else if (TMO_EN && (wdog_q == TMO_LAST)) begin
          state_d   = ST_HANDOVER;
          fault_d   = fault_q | gnt_q;
          blocked_d = blocked_d | gnt_q;
          gnt_d     = '0;
          busy_d    = 1'b0;
          wdog_d    = '0;
        end else if (TMO_EN) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_HANDOVER: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        wdog_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        wdog_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      fault_q   <= '0;
      blocked_q <= '0;
      ptr_q     <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
      blocked_q <= blocked_d;
      ptr_q     <= ptr_d;
      wdog_q    <= wdog_d;
    end
  end

  // Resource mux: gnt_q is one-hot in GRANT and zero elsewhere (including
  // while reset is asserted), so an AND-OR mux forces everything to 0
  // outside GRANT without looking at the state.
  always_comb begin : route
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    bus_go    = 1'b0;
    bus_rw    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    sha_init  = 1'b0;
    sha_next  = 1'b0;
    sha_sel   = 1'b0;
    sha_block = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        mem_rd_en = mem_rd_en | r_mem_rd_en[i];
        mem_wr_en = mem_wr_en | r_mem_wr_en[i];
        mem_addr  = mem_addr  | r_mem_addr[i*MEM_AW +: MEM_AW];
        mem_wdata = mem_wdata | r_mem_wdata[i*MEM_DW +: MEM_DW];
        bus_go    = bus_go    | r_bus_go[i];
        bus_rw    = bus_rw    | r_bus_rw[i];
        bus_addr  = bus_addr  | r_bus_addr[i*BUS_AW +: BUS_AW];
        bus_wdata = bus_wdata | r_bus_wdata[i*BUS_DW +: BUS_DW];
        sha_init  = sha_init  | r_sha_init[i];
        sha_next  = sha_next  | r_sha_next[i];
        sha_sel   = sha_sel   | r_sha_sel[i];
        sha_block = sha_block | r_sha_block[i*512 +: 512];
      end
    end
  end

  assign r_mem_rdata_valid = gnt_q & {N_REQ{mem_rdata_valid}};
  assign r_bus_done        = gnt_q & {N_REQ{bus_done}};

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mcse_resource_arbiter.sv
// Bench for mcse_resource_arbiter: one fixed-priority and one round-robin
// instance (both with an 8-cycle watchdog) share the same stimulus.
module tb_mcse_resource_arbiter;
  localparam int N   = 4;
  localparam int MAW = 6;
  localparam int MDW = 256;
  localparam int BAW = 32;
  localparam int BDW = 256;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req, req_mask;
  logic [N-1:0] r_mem_rd_en, r_mem_wr_en, r_bus_go, r_bus_rw;
  logic [N-1:0] r_sha_init, r_sha_next, r_sha_sel;
  logic [N*MAW-1:0] r_mem_addr;
  logic [N*MDW-1:0] r_mem_wdata;
  logic [N*BAW-1:0] r_bus_addr;
  logic [N*BDW-1:0] r_bus_wdata;
  logic [N*512-1:0] r_sha_block;
  logic mem_rdata_valid, bus_done;

  // Index 0: ARB_MODE 0 (fixed priority); index 1: ARB_MODE 1 (round-robin).
  logic [N-1:0]   o_gnt [2];
  logic           o_busy [2];
  logic [N-1:0]   o_fault [2];
  logic           o_mem_rd_en [2];
  logic           o_mem_wr_en [2];
  logic [MAW-1:0] o_mem_addr [2];
  logic [MDW-1:0] o_mem_wdata [2];
  logic [N-1:0]   o_r_mem_rdata_valid [2];
  logic           o_bus_go [2];
  logic           o_bus_rw [2];
  logic [BAW-1:0] o_bus_addr [2];
  logic [BDW-1:0] o_bus_wdata [2];
  logic [N-1:0]   o_r_bus_done [2];
  logic           o_sha_init [2];
  logic           o_sha_next [2];
  logic           o_sha_sel [2];
  logic [511:0]   o_sha_block [2];
  logic [1:0]     o_dbg_state [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mcse_resource_arbiter #(
      .N_REQ(N), .MEM_AW(MAW), .MEM_DW(MDW), .BUS_AW(BAW), .BUS_DW(BDW),
      .ARB_MODE(g), .TIMEOUT_CYCLES(TMO)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_mask(req_mask),
      .gnt(o_gnt[g]), .busy(o_busy[g]), .fault(o_fault[g]),
      .r_mem_rd_en(r_mem_rd_en), .r_mem_wr_en(r_mem_wr_en),
      .r_mem_addr(r_mem_addr), .r_mem_wdata(r_mem_wdata),
      .r_bus_go(r_bus_go), .r_bus_rw(r_bus_rw),
      .r_bus_addr(r_bus_addr), .r_bus_wdata(r_bus_wdata),
      .r_sha_init(r_sha_init), .r_sha_next(r_sha_next), .r_sha_sel(r_sha_sel),
      .r_sha_block(r_sha_block),
      .mem_rd_en(o_mem_rd_en[g]), .mem_wr_en(o_mem_wr_en[g]),
      .mem_addr(o_mem_addr[g]), .mem_wdata(o_mem_wdata[g]),
      .mem_rdata_valid(mem_rdata_valid), .r_mem_rdata_valid(o_r_mem_rdata_valid[g]),
      .bus_go(o_bus_go[g]), .bus_rw(o_bus_rw[g]),
      .bus_addr(o_bus_addr[g]), .bus_wdata(o_bus_wdata[g]),
      .bus_done(bus_done), .r_bus_done(o_r_bus_done[g]),
      .sha_init(o_sha_init[g]), .sha_next(o_sha_next[g]), .sha_sel(o_sha_sel[g]),
      .sha_block(o_sha_block[g]), .dbg_state(o_dbg_state[g])
    );
  end

  // ---------------- reference model (random test) ----------------
  // Tracks who owns the resource, how long it has held it, and how many
  // forced-idle cycles remain before a new grant is allowed.
  int           m_owner [2];
  int           m_hold [2];
  int           m_gap [2];
  int           m_ptr [2];
  logic [N-1:0] m_blocked [2];
  logic [N-1:0] m_fault [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1; m_hold[m] = 0; m_gap[m] = 0; m_ptr[m] = 0;
      m_blocked[m] = '0; m_fault[m] = '0;
    end
  endtask

  // Advance one clock edge using the inputs that were stable before it.
  task automatic model_step(input int m);
    logic [N-1:0] nb;
    int o, w, idx;
    nb = m_blocked[m] & req;
    o  = m_owner[m];
    if (o >= 0) begin
      if (!(req[o] && !req_mask[o])) begin
        m_owner[m] = -1; m_gap[m] = 1;
      end else if (m_hold[m] == TMO - 1) begin
        m_fault[m][o] = 1'b1; nb[o] = 1'b1;
        m_owner[m] = -1; m_gap[m] = 1;
      end else begin
        m_hold[m]++;
      end
    end else if (m_gap[m] > 0) begin
      m_gap[m]--;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m == 1) ? (m_ptr[m] + k) % N : k;
        if (w < 0 && req[idx] && !req_mask[idx] && !m_blocked[m][idx]) w = idx;
      end
      if (w >= 0) begin
        m_owner[m] = w; m_hold[m] = 0; m_ptr[m] = (w + 1) % N;
      end
    end
    m_blocked[m] = nb;
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req = '0; req_mask = '0;
    r_mem_rd_en = '0; r_mem_wr_en = '0; r_bus_go = '0; r_bus_rw = '0;
    r_sha_init = '0; r_sha_next = '0; r_sha_sel = '0;
    r_mem_addr = '0; r_mem_wdata = '0; r_bus_addr = '0; r_bus_wdata = '0;
    r_sha_block = '0; mem_rdata_valid = 1'b0; bus_done = 1'b0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      r_mem_addr[i*MAW +: MAW] = MAW'($urandom);
      r_bus_addr[i*BAW +: BAW] = $urandom;
      for (int j = 0; j < MDW/32; j++) r_mem_wdata[i*MDW + j*32 +: 32] = $urandom;
      for (int j = 0; j < BDW/32; j++) r_bus_wdata[i*BDW + j*32 +: 32] = $urandom;
      for (int j = 0; j < 16; j++)     r_sha_block[i*512 + j*32 +: 32] = $urandom;
    end
    r_mem_rd_en = N'($urandom); r_mem_wr_en = N'($urandom);
    r_bus_go = N'($urandom); r_bus_rw = N'($urandom);
    r_sha_init = N'($urandom); r_sha_next = N'($urandom); r_sha_sel = N'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    rand_payload();
    mem_rdata_valid = 1'b1; bus_done = 1'b1;
    req = '1;
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      checks++; if (o_gnt[m] !== '0) begin errors++; $display("FAIL reset_gnt[%0d]: got %b expected 0000", m, o_gnt[m]); end
      checks++; if (o_busy[m] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", m, o_busy[m]); end
      checks++; if (o_fault[m] !== '0) begin errors++; $display("FAIL reset_fault[%0d]: got %b expected 0000", m, o_fault[m]); end
      checks++; if ({o_mem_rd_en[m], o_mem_wr_en[m], o_mem_addr[m], o_bus_addr[m], o_sha_init[m]} !== '0)
        begin errors++; $display("FAIL reset_outputs[%0d]: got rd=%b wr=%b addr=%h baddr=%h expected all 0", m, o_mem_rd_en[m], o_mem_wr_en[m], o_mem_addr[m], o_bus_addr[m]); end
      checks++; if ({o_r_mem_rdata_valid[m], o_r_bus_done[m]} !== '0)
        begin errors++; $display("FAIL reset_return[%0d]: got %b %b expected 0", m, o_r_mem_rdata_valid[m], o_r_bus_done[m]); end
    end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_fixed_priority();
    logic [MAW-1:0] exp_addr;
    do_reset();
    rand_payload();
    exp_addr = r_mem_addr[1*MAW +: MAW];
    req = 4'b0110;
    step();  // cycle 1
    checks++; if (o_gnt[0] !== 4'b0010) begin errors++; $display("FAIL fp_first_gnt: got %b expected 0010", o_gnt[0]); end
    checks++; if (o_busy[0] !== 1'b1) begin errors++; $display("FAIL fp_busy: got %b expected 1", o_busy[0]); end
    checks++; if (o_mem_addr[0] !== exp_addr) begin errors++; $display("FAIL fp_mem_addr: got %h expected %h", o_mem_addr[0], exp_addr); end
    for (int c = 2; c <= 5; c++) begin
      step();
      checks++; if (o_gnt[0] !== 4'b0010) begin errors++; $display("FAIL fp_hold_c%0d: got %b expected 0010", c, o_gnt[0]); end
    end
    req = 4'b0100;  // req[1] low at cycle 5
    step();  // cycle 6
    checks++; if (o_gnt[0] !== 4'b0000) begin errors++; $display("FAIL fp_handover: got %b expected 0000", o_gnt[0]); end
    checks++; if (o_busy[0] !== 1'b0) begin errors++; $display("FAIL fp_handover_busy: got %b expected 0", o_busy[0]); end
    checks++; if (o_mem_addr[0] !== '0) begin errors++; $display("FAIL fp_handover_addr: got %h expected 0", o_mem_addr[0]); end
    step();  // cycle 7
    checks++; if (o_gnt[0] !== 4'b0000) begin errors++; $display("FAIL fp_idle: got %b expected 0000", o_gnt[0]); end
    step();  // cycle 8
    checks++; if (o_gnt[0] !== 4'b0100) begin errors++; $display("FAIL fp_second_gnt: got %b expected 0100", o_gnt[0]); end
    // A higher-priority request must not preempt the current owner.
    req = 4'b0101;
    step(); step();
    checks++; if (o_gnt[0] !== 4'b0100) begin errors++; $display("FAIL fp_no_preempt: got %b expected 0100", o_gnt[0]); end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp;
    int waited, own;
    do_reset();
    exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = '1;
    for (int g = 0; g < 5; g++) begin
      exp = exp_q.pop_front();
      own = g % N;
      waited = 0;
      while (o_gnt[1] === '0 && waited < 10) begin step(); waited++; end
      checks++; if (o_gnt[1] !== exp) begin errors++; $display("FAIL rr_order_%0d: got %b expected %b (waited %0d)", g, o_gnt[1], exp, waited); end
      if (g > 0) begin
        checks++; if (waited < 1) begin errors++; $display("FAIL rr_gap_%0d: got %0d idle cycles expected at least 1", g, waited); end
      end
      step(); step();
      checks++; if (o_gnt[1] !== exp) begin errors++; $display("FAIL rr_hold_%0d: got %b expected %b", g, o_gnt[1], exp); end
      req[own] = 1'b0;
      step();
      checks++; if (o_gnt[1] !== '0) begin errors++; $display("FAIL rr_release_%0d: got %b expected 0000", g, o_gnt[1]); end
      req = '1;
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0100;
    step();
    checks++; if (o_gnt[0] !== 4'b0100) begin errors++; $display("FAIL tmo_grant: got %b expected 0100", o_gnt[0]); end
    for (int c = 1; c < TMO; c++) begin
      step();
      checks++; if (o_gnt[0] !== 4'b0100 || o_fault[0] !== '0)
        begin errors++; $display("FAIL tmo_hold_c%0d: got gnt=%b fault=%b expected 0100/0000", c, o_gnt[0], o_fault[0]); end
    end
    step();  // TMO cycles after the grant
    for (int m = 0; m < 2; m++) begin
      checks++; if (o_gnt[m] !== '0) begin errors++; $display("FAIL tmo_drop[%0d]: got %b expected 0000", m, o_gnt[m]); end
      checks++; if (o_fault[m] !== 4'b0100) begin errors++; $display("FAIL tmo_fault[%0d]: got %b expected 0100", m, o_fault[m]); end
    end
    repeat (4) step();
    checks++; if (o_gnt[0] !== '0 || o_busy[0] !== 1'b0)
      begin errors++; $display("FAIL tmo_blocked: got gnt=%b busy=%b expected 0000/0", o_gnt[0], o_busy[0]); end
    req = 4'b0000;
    step();
    req = 4'b0100;
    step();
    checks++; if (o_gnt[0] !== 4'b0100) begin errors++; $display("FAIL tmo_regrant: got %b expected 0100", o_gnt[0]); end
    checks++; if (o_fault[0] !== 4'b0100) begin errors++; $display("FAIL tmo_sticky: got %b expected 0100", o_fault[0]); end
    clear_inputs();
    repeat (3) step();
  endtask

  task automatic test_mask();
    do_reset();
    req = 4'b0001;
    step();
    checks++; if (o_gnt[0] !== 4'b0001) begin errors++; $display("FAIL mask_grant: got %b expected 0001", o_gnt[0]); end
    req_mask = 4'b0001;
    step();
    checks++; if (o_gnt[0] !== '0 || o_busy[0] !== 1'b0)
      begin errors++; $display("FAIL mask_revoke: got gnt=%b busy=%b expected 0000/0", o_gnt[0], o_busy[0]); end
    repeat (3) step();
    checks++; if (o_gnt[0] !== '0 || o_busy[0] !== 1'b0)
      begin errors++; $display("FAIL mask_no_grant: got gnt=%b busy=%b expected 0000/0", o_gnt[0], o_busy[0]); end
    req = 4'b0011;
    step();
    checks++; if (o_gnt[0] !== 4'b0010) begin errors++; $display("FAIL mask_skip: got %b expected 0010", o_gnt[0]); end
    clear_inputs();
  endtask

  task automatic test_routing();
    logic [MDW-1:0] exp_wd;
    logic [BAW-1:0] exp_ba;
    logic [511:0]   exp_sb;
    do_reset();
    rand_payload();
    r_mem_wr_en = 4'b0000;
    req = 4'b0010;
    step();
    mem_rdata_valid = 1'b1; bus_done = 1'b1;
    #1;
    checks++; if (o_r_mem_rdata_valid[0] !== 4'b0010) begin errors++; $display("FAIL route_rdv: got %b expected 0010", o_r_mem_rdata_valid[0]); end
    checks++; if (o_r_bus_done[0] !== 4'b0010) begin errors++; $display("FAIL route_done: got %b expected 0010", o_r_bus_done[0]); end
    r_mem_wr_en = 4'b1101;
    #1;
    checks++; if (o_mem_wr_en[0] !== 1'b0) begin errors++; $display("FAIL route_nonowner_wr: got %b expected 0", o_mem_wr_en[0]); end
    r_mem_wr_en = 4'b0010;
    #1;
    checks++; if (o_mem_wr_en[0] !== 1'b1) begin errors++; $display("FAIL route_owner_wr: got %b expected 1", o_mem_wr_en[0]); end
    exp_wd = r_mem_wdata[1*MDW +: MDW];
    exp_ba = r_bus_addr[1*BAW +: BAW];
    exp_sb = r_sha_block[1*512 +: 512];
    checks++; if (o_mem_wdata[0] !== exp_wd) begin errors++; $display("FAIL route_wdata: got %h expected %h", o_mem_wdata[0], exp_wd); end
    checks++; if (o_bus_addr[0] !== exp_ba) begin errors++; $display("FAIL route_bus_addr: got %h expected %h", o_bus_addr[0], exp_ba); end
    checks++; if (o_sha_block[0] !== exp_sb) begin errors++; $display("FAIL route_sha_block: got %h expected %h", o_sha_block[0], exp_sb); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0001;
    r_mem_rd_en = 4'b0001;
    step();
    checks++; if (o_mem_rd_en[0] !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b expected 1", o_mem_rd_en[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_gnt[0] !== '0 || o_busy[0] !== 1'b0)
      begin errors++; $display("FAIL rstmid_gnt: got gnt=%b busy=%b expected 0000/0", o_gnt[0], o_busy[0]); end
    checks++; if (o_mem_rd_en[0] !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %b expected 0", o_mem_rd_en[0]); end
    checks++; if (o_fault[0] !== '0) begin errors++; $display("FAIL rstmid_fault: got %b expected 0000", o_fault[0]); end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int o;
    logic [MAW-1:0] e_addr;
    logic           e_wr;
    logic [N-1:0]   e_rdv, e_gnt;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 31) == 0)
        for (int i = 0; i < N; i++) req_mask[i] = ($urandom_range(0, 3) == 0);
      rand_payload();
      mem_rdata_valid = 1'($urandom_range(0, 1));
      bus_done = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        o = m_owner[m];
        e_gnt  = (o >= 0) ? N'(1 << o) : '0;
        e_addr = (o >= 0) ? r_mem_addr[o*MAW +: MAW] : '0;
        e_wr   = (o >= 0) ? r_mem_wr_en[o] : 1'b0;
        e_rdv  = mem_rdata_valid ? e_gnt : '0;
        checks++; if (o_gnt[m] !== e_gnt) begin errors++; $display("FAIL rnd_gnt[%0d] cyc %0d: got %b expected %b", m, cyc, o_gnt[m], e_gnt); end
        checks++; if (o_busy[m] !== (o >= 0)) begin errors++; $display("FAIL rnd_busy[%0d] cyc %0d: got %b expected %b", m, cyc, o_busy[m], (o >= 0)); end
        checks++; if (o_fault[m] !== m_fault[m]) begin errors++; $display("FAIL rnd_fault[%0d] cyc %0d: got %b expected %b", m, cyc, o_fault[m], m_fault[m]); end
        checks++; if (o_mem_addr[m] !== e_addr || o_mem_wr_en[m] !== e_wr)
          begin errors++; $display("FAIL rnd_mem[%0d] cyc %0d: got %h/%b expected %h/%b", m, cyc, o_mem_addr[m], o_mem_wr_en[m], e_addr, e_wr); end
        checks++; if (o_r_mem_rdata_valid[m] !== e_rdv) begin errors++; $display("FAIL rnd_rdv[%0d] cyc %0d: got %b expected %b", m, cyc, o_r_mem_rdata_valid[m], e_rdv); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_reset_mid_grant();
    test_timeout();
    test_mask();
    test_routing();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
